// File: rtl/ctrl_seq_decoder_if.sv
// ctrl_seq_decoder_if: control-code bus between the calculator sequencer
// (master: drives the 2-bit code stream) and the receive-side checker
// (slave: returns frame status).
interface ctrl_seq_decoder_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       code;
  logic             code_vld;
  logic             mode;
  logic             done;
  logic             err;
  logic [1:0]       err_why;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
  logic [7:0]       err_cnt;

  modport master (
    output code, code_vld,
    input  mode, done, err, err_why, busy, frame_cnt, err_cnt
  );

  modport slave (
    input  code, code_vld,
    output mode, done, err, err_why, busy, frame_cnt, err_cnt
  );
endinterface

// File: rtl/ctrl_seq_decoder.sv
// ctrl_seq_decoder: tracks the sequencer's Gray-style control code stream,
// recovers the frame mode bit, flags good frames, bad codes and stalls.
// Optional feature macro: CTRL_SEQ_ERR_COUNT_EN (saturating error counter;
// when undefined err_cnt is tied to zero).
module ctrl_seq_decoder #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  ctrl_seq_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PRE   = 3'd2,
    S01   = 3'd3,
    S11   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_mode_int;
  logic             w_mode_int_nxt;
  logic             w_bad;
  logic             w_good;
  logic             w_tout;
  logic             w_tout_hit;

  logic             r_mode;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_why;
  logic             r_busy;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_mode_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic [1:0]       w_why_nxt;
  logic [CNT_W-1:0] w_frame_nxt;

  // Stall detection: counts idle cycles mid-frame; absent when TIMEOUT is 0
  generate
    if (TIMEOUT > 0) begin : g_tout
      localparam int IW = $clog2(TIMEOUT + 1);
      logic [IW-1:0] r_idle_cnt;

      // Idle counter: clears on valid cycles and whenever IDLE is current or next
      always_ff @(posedge clk) begin
        if (rst) begin
          r_idle_cnt <= '0;
        end else if (bus.code_vld || r_state == IDLE || w_next == IDLE) begin
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + IW'(1);
        end
      end

      // Fires on the idle cycle that brings the count up to TIMEOUT
      assign w_tout_hit = !bus.code_vld && (r_state != IDLE) &&
                          (r_idle_cnt == IW'(TIMEOUT - 1));
    end else begin : g_no_tout
      assign w_tout_hit = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mode_int <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mode_int <= w_mode_int_nxt;
    end
  end

  // Next-state decode: legal code steps, bad codes with 00 resync, timeout
  always_comb begin
    w_next         = r_state;
    w_mode_int_nxt = r_mode_int;
    w_bad          = 1'b0;
    w_good         = 1'b0;
    w_tout         = 1'b0;
    if (bus.code_vld) begin
      unique case (r_state)
        IDLE: begin
          if (bus.code == 2'b00) w_next = START;
        end
        START: begin
          if (bus.code == 2'b00) begin
            w_next         = PRE;
            w_mode_int_nxt = 1'b0;
          end else if (bus.code == 2'b01) begin
            w_next         = S01;
            w_mode_int_nxt = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
        PRE: begin
          if (bus.code == 2'b01) w_next = S01;
          else                   w_bad  = 1'b1;
        end
        S01: begin
          if (bus.code == 2'b11) w_next = S11;
          else                   w_bad  = 1'b1;
        end
        S11: begin
          if (bus.code == 2'b10) begin
            w_next = IDLE;
            w_good = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
      if (w_bad) w_next = (bus.code == 2'b00) ? START : IDLE;
    end else if (w_tout_hit) begin
      w_tout = 1'b1;
      w_next = IDLE;
    end
  end

  // Output decode: next values of the registered status outputs
  always_comb begin
    w_done_nxt  = w_good;
    w_err_nxt   = w_bad | w_tout;
    w_mode_nxt  = r_mode;
    w_why_nxt   = r_err_why;
    w_frame_nxt = r_frame_cnt;
    if (w_good) begin
      w_mode_nxt  = r_mode_int;
      w_frame_nxt = r_frame_cnt + CNT_W'(1);
    end
    if (w_bad)       w_why_nxt = 2'b01;
    else if (w_tout) w_why_nxt = 2'b10;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_why   <= 2'b00;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_why   <= w_why_nxt;
      r_busy      <= (w_next != IDLE);
      r_frame_cnt <= w_frame_nxt;
    end
  end

`ifdef CTRL_SEQ_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  // Saturating error counter, advances with each err pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && r_err_cnt != '1) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.mode      = r_mode;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_why   = r_err_why;
  assign bus.busy      = r_busy;
  assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// tb_ctrl_seq_decoder: directed vectors with hand-computed expectations
// for ctrl_seq_decoder (TIMEOUT=4, CNT_W=8).
module tb_ctrl_seq_decoder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [7:0] exp_ecnt;

  ctrl_seq_decoder_if #(.CNT_W(8)) u_if ();

  ctrl_seq_decoder #(
    .CNT_W   (8),
    .TIMEOUT (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one code, let one rising edge sample it, return 1 ns after it
  task automatic step(input logic [1:0] c, input logic v);
    u_if.code     = c;
    u_if.code_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mode"},  32'(u_if.mode), 0);
    check({tag, "_done"},  32'(u_if.done), 0);
    check({tag, "_err"},   32'(u_if.err), 0);
    check({tag, "_why"},   32'(u_if.err_why), 0);
    check({tag, "_busy"},  32'(u_if.busy), 0);
    check({tag, "_fcnt"},  32'(u_if.frame_cnt), 0);
    check({tag, "_ecnt"},  32'(u_if.err_cnt), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    u_if.code = 2'b00;
    u_if.code_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("rst");

    // Non-00 code in IDLE is ignored
    step(2'b11, 1'b1);
    check("idle_ign_busy", 32'(u_if.busy), 0);
    check("idle_ign_err",  32'(u_if.err), 0);

    // Mode-1 frame
    step(2'b00, 1'b1); check("m1_busy0", 32'(u_if.busy), 1);
    step(2'b01, 1'b1); check("m1_busy1", 32'(u_if.busy), 1);
    step(2'b11, 1'b1); check("m1_busy2", 32'(u_if.busy), 1);
    check("m1_done_early", 32'(u_if.done), 0);
    step(2'b10, 1'b1);
    check("m1_done", 32'(u_if.done), 1);
    check("m1_mode", 32'(u_if.mode), 1);
    check("m1_fcnt", 32'(u_if.frame_cnt), 1);
    check("m1_err",  32'(u_if.err), 0);
    check("m1_busy", 32'(u_if.busy), 0);
    step(2'b00, 1'b0);
    check("m1_done_pulse", 32'(u_if.done), 0);
    check("m1_mode_hold",  32'(u_if.mode), 1);

    // Mode-0 frame then back-to-back mode-1 frame
    step(2'b00, 1'b1); step(2'b00, 1'b1); step(2'b01, 1'b1); step(2'b11, 1'b1);
    check("m0_mode_pre", 32'(u_if.mode), 1);
    step(2'b10, 1'b1);
    check("m0_done", 32'(u_if.done), 1);
    check("m0_mode", 32'(u_if.mode), 0);
    check("m0_fcnt", 32'(u_if.frame_cnt), 2);
    step(2'b00, 1'b1);
    check("b2b_done_off", 32'(u_if.done), 0);
    check("b2b_busy",     32'(u_if.busy), 1);
    step(2'b01, 1'b1); step(2'b11, 1'b1); step(2'b10, 1'b1);
    check("b2b_done", 32'(u_if.done), 1);
    check("b2b_mode", 32'(u_if.mode), 1);
    check("b2b_fcnt", 32'(u_if.frame_cnt), 3);

    // Bad code 10 after 01 -> error, back to IDLE
    step(2'b00, 1'b1); step(2'b01, 1'b1); step(2'b10, 1'b1);
    check("bad_err",  32'(u_if.err), 1);
    check("bad_why",  32'(u_if.err_why), 1);
    check("bad_busy", 32'(u_if.busy), 0);
    check("bad_done", 32'(u_if.done), 0);
    step(2'b01, 1'b1);
    check("bad_err_pulse", 32'(u_if.err), 0);
    check("bad_idle", 32'(u_if.busy), 0);

    // Bad 00 resyncs to START, frame then completes as mode 1
    step(2'b00, 1'b1); step(2'b01, 1'b1); step(2'b00, 1'b1);
    check("rs_err",  32'(u_if.err), 1);
    check("rs_why",  32'(u_if.err_why), 1);
    check("rs_busy", 32'(u_if.busy), 1);
    step(2'b01, 1'b1); step(2'b11, 1'b1); step(2'b10, 1'b1);
    check("rs_done", 32'(u_if.done), 1);
    check("rs_mode", 32'(u_if.mode), 1);
    check("rs_fcnt", 32'(u_if.frame_cnt), 4);
    check("rs_why_hold", 32'(u_if.err_why), 1);

    // Timeout: fires on the 4th idle cycle after the last valid code
    step(2'b00, 1'b1); step(2'b01, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      step(2'b00, 1'b0);
      check("to_early", 32'(u_if.err), 0);
    end
    step(2'b00, 1'b0);
    check("to_err",  32'(u_if.err), 1);
    check("to_why",  32'(u_if.err_why), 2);
    check("to_busy", 32'(u_if.busy), 0);
    step(2'b00, 1'b0);
    check("to_pulse", 32'(u_if.err), 0);

    // Gaps of 3 idle cycles between codes never time out
    step(2'b00, 1'b1);
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned i = 0; i < 3; i++) step(2'b00, 1'b0);
      check("gap_err",  32'(u_if.err), 0);
      check("gap_busy", 32'(u_if.busy), 1);
      case (k)
        0: step(2'b01, 1'b1);
        1: step(2'b11, 1'b1);
        default: step(2'b10, 1'b1);
      endcase
    end
    check("gap_done", 32'(u_if.done), 1);
    check("gap_fcnt", 32'(u_if.frame_cnt), 5);
    check("gap_why_hold", 32'(u_if.err_why), 2);

    // Reset mid-frame, then the tail of the aborted frame yields nothing
    step(2'b00, 1'b1); step(2'b00, 1'b1); step(2'b01, 1'b1);
    rst = 1'b1;
    step(2'b11, 1'b1);
    rst = 1'b0;
    check_reset_state("mid_rst");
    step(2'b11, 1'b1);
    check("abort_done0", 32'(u_if.done), 0);
    step(2'b10, 1'b1);
    check("abort_done1", 32'(u_if.done), 0);
    check("abort_err",   32'(u_if.err), 0);
    check("abort_busy",  32'(u_if.busy), 0);

    // frame_cnt wraps from 255 to 0
    for (int unsigned f = 0; f < 255; f++) begin
      step(2'b00, 1'b1); step(2'b01, 1'b1); step(2'b11, 1'b1); step(2'b10, 1'b1);
    end
    check("wrap_255", 32'(u_if.frame_cnt), 255);
    step(2'b00, 1'b1); step(2'b01, 1'b1); step(2'b11, 1'b1); step(2'b10, 1'b1);
    check("wrap_0",    32'(u_if.frame_cnt), 0);
    check("wrap_done", 32'(u_if.done), 1);

    // Error counter: 260 bad frames (00,10)
    for (int unsigned e = 0; e < 260; e++) begin
      step(2'b00, 1'b1);
      step(2'b10, 1'b1);
      if (e == 0) begin
        check("ec_err", 32'(u_if.err), 1);
        check("ec_done", 32'(u_if.done), 0);
      end
      if (e == 2) begin
`ifdef CTRL_SEQ_ERR_COUNT_EN
        exp_ecnt = 8'd3;
`else
        exp_ecnt = 8'd0;
`endif
        check("ec_3", 32'(u_if.err_cnt), 32'(exp_ecnt));
      end
    end
`ifdef CTRL_SEQ_ERR_COUNT_EN
    exp_ecnt = 8'd255;
`else
    exp_ecnt = 8'd0;
`endif
    check("ec_sat", 32'(u_if.err_cnt), 32'(exp_ecnt));
    check("ec_fcnt_hold", 32'(u_if.frame_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
